force_release_bank: RTL and testbench

- Multi-channel register bank that models procedural force/release semantics in synthesizable RTL: each channel is a WIDTH-bit register with a normal write path and a force override.
- Optional periodic re-force re-applies a channel's stored force value every PERIOD cycles, even after the channel has been released.
- Used as a checked reference model for force/release regression benches and as a debug override stage on state registers.

---
 rtl/force_release_bank.sv | 64 ++++++
 tb/tb_force_release_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/force_release_bank.sv
// rtl/force_release_bank.sv - per-channel register bank with force/release override and periodic re-force
module force_release_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int PERIOD   = 10,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      force_en,
  input  logic [CW-1:0]             force_ch,
  input  logic [WIDTH-1:0]          force_data,
  input  logic                      release_en,
  input  logic [CW-1:0]             release_ch,
  input  logic                      period_en,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       forced,
  output logic [CHANNELS-1:0]       armed,
  output logic                      tick
);

  localparam int CNTW = $clog2(PERIOD);
  localparam logic [CNTW-1:0] LAST = CNTW'(PERIOD - 1);

  logic [CNTW-1:0]  count;
  logic [WIDTH-1:0] fval [CHANNELS];

  assign tick = (count == LAST);

  // Channel indices >= CHANNELS never match any loop index, so such strobes fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      q      <= '0;
      forced <= '0;
      armed  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        fval[i] <= '0;
      end
    end else begin
      count <= tick ? '0 : count + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (force_en && force_ch == CW'(i)) begin
          fval[i]              <= force_data;
          q[i*WIDTH +: WIDTH]  <= force_data;
          forced[i]            <= 1'b1;
          armed[i]             <= period_en;
        end else if (release_en && release_ch == CW'(i)) begin
          forced[i] <= 1'b0;
          armed[i]  <= armed[i] & period_en;
        end else if (tick && armed[i] && !forced[i]) begin
          q[i*WIDTH +: WIDTH] <= fval[i];
          forced[i]           <= 1'b1;
        end else if (wr_en && wr_ch == CW'(i) && !forced[i]) begin
          q[i*WIDTH +: WIDTH] <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_force_release_bank.sv
// tb/tb_force_release_bank.sv - directed self-checking bench for force_release_bank
module tb_force_release_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, force_en, release_en, period_en;
  logic [1:0]  wr_ch, force_ch, release_ch;
  logic [3:0]  wr_data, force_data;
  logic [15:0] q;
  logic [3:0]  forced, armed;
  logic        tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  force_release_bank #(.WIDTH(4), .CHANNELS(4), .PERIOD(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .force_en(force_en), .force_ch(force_ch), .force_data(force_data),
    .release_en(release_en), .release_ch(release_ch),
    .period_en(period_en),
    .q(q), .forced(forced), .armed(armed), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] qv(input int i);
    return q[i*4 +: 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    wr_en = 1'b0; force_en = 1'b0; release_en = 1'b0; period_en = 1'b0;
  endtask

  task automatic do_force(input logic [1:0] ch, input logic [3:0] d, input logic pe);
    force_en = 1'b1; force_ch = ch; force_data = d; period_en = pe;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [3:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
  endtask

  task automatic do_release(input logic [1:0] ch, input logic pe);
    release_en = 1'b1; release_ch = ch; period_en = pe;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; force_en = 1'b0; release_en = 1'b0; period_en = 1'b0;
    wr_ch = '0; force_ch = '0; release_ch = '0; wr_data = '0; force_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", q, 16'h0000);
    chk("reset_forced", forced, 4'h0);
    chk("reset_armed", armed, 4'h0);
    chk("reset_tick", tick, 1'b0);
    rst_n = 1'b1;
    cyc = 0;

    for (int k = 0; k < 15; k++) begin
      step();
      chk("idle_tick", tick, (cyc == 9) ? 1'b1 : 1'b0);
    end
    chk("idle_q", q, 16'h0000);
    chk("idle_forced", forced, 4'h0);

    // One-shot force, blocked write, release keeps value, write lands
    do_force(2'd1, 4'h5, 1'b0); step();
    chk("f1_q", qv(1), 4'h5);
    chk("f1_forced", forced[1], 1'b1);
    chk("f1_armed", armed[1], 1'b0);
    do_write(2'd1, 4'hA); step();
    chk("f1_wr_blocked", qv(1), 4'h5);
    do_release(2'd1, 1'b0); step();
    chk("r1_q", qv(1), 4'h5);
    chk("r1_forced", forced[1], 1'b0);
    do_write(2'd1, 4'hA); step();
    chk("w1_q", qv(1), 4'hA);

    // Periodic force on ch2, released but still armed
    do_force(2'd2, 4'h3, 1'b1); step();
    chk("f2_q", qv(2), 4'h3);
    chk("f2_armed", armed[2], 1'b1);
    do_release(2'd2, 1'b1); step();
    chk("r2_forced", forced[2], 1'b0);
    chk("r2_armed", armed[2], 1'b1);
    do_write(2'd2, 4'h9); step();
    chk("w2_q", qv(2), 4'h9);
    while (cyc < 29) step();
    chk("w2_hold", qv(2), 4'h9);
    chk("tick29", tick, 1'b1);
    step();
    chk("reforce2_q", qv(2), 4'h3);
    chk("reforce2_forced", forced[2], 1'b1);

    // Same-cycle collisions
    do_force(2'd0, 4'hC, 1'b0); do_release(2'd0, 1'b0); step();
    chk("fr0_forced", forced[0], 1'b1);
    chk("fr0_q", qv(0), 4'hC);
    do_write(2'd3, 4'h7); do_force(2'd3, 4'h1, 1'b0); step();
    chk("wf3_q", qv(3), 4'h1);
    chk("wf3_forced", forced[3], 1'b1);
    do_write(2'd0, 4'h6); do_release(2'd0, 1'b0); step();
    chk("wr0_q", qv(0), 4'hC);
    chk("wr0_forced", forced[0], 1'b0);

    // Disarm ch2: later ticks must not re-force it
    do_release(2'd2, 1'b0); step();
    chk("r2d_armed", armed[2], 1'b0);
    chk("r2d_q", qv(2), 4'h3);
    do_write(2'd2, 4'h4); step();
    chk("w2d_q", qv(2), 4'h4);
    while (cyc < 62) begin
      step();
      chk("disarm_hold", qv(2), 4'h4);
    end
    chk("disarm_forced", forced[2], 1'b0);
    chk("ch3_still", qv(3), 4'h1);

    // Release coinciding with tick: release wins, re-force on next tick
    do_force(2'd3, 4'hB, 1'b1); step();
    chk("f3_q", qv(3), 4'hB);
    chk("f3_armed", armed[3], 1'b1);
    while (cyc < 69) step();
    chk("tick69", tick, 1'b1);
    do_release(2'd3, 1'b1); step();
    chk("rt3_forced", forced[3], 1'b0);
    chk("rt3_q", qv(3), 4'hB);
    do_write(2'd3, 4'h2); step();
    chk("wt3_q", qv(3), 4'h2);
    while (cyc < 80) step();
    chk("reforce3_q", qv(3), 4'hB);
    chk("reforce3_forced", forced[3], 1'b1);

    // Asynchronous reset while ch1 is forced and armed
    do_force(2'd1, 4'h6, 1'b1); step();
    chk("f1p_armed", armed[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q, 16'h0000);
    chk("arst_forced", forced, 4'h0);
    chk("arst_armed", armed, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    chk("rel_tick", tick, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_tick", tick, (cyc == 9) ? 1'b1 : 1'b0);
    end
    chk("post_q", q, 16'h0000);
    chk("post_forced", forced, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
